// File: rtl/serial_sub_ctrl.sv
// Bit-serial unsigned subtractor controller: time-shares one external full-subtractor
// cell, LSB first, one bit per clock, with a start/busy/done handshake.
module serial_sub_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             borrow_out,
    output logic             zero,
    output logic             fs_a,
    output logic             fs_b,
    output logic             fs_bin,
    input  logic             fs_diff,
    input  logic             fs_bout
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] res_nxt_s;
    logic             brw_q, brw_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             zero_q, zero_d;

    // State, datapath and result registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            res_q    <= '0;
            brw_q    <= 1'b0;
            cnt_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            res_q    <= res_d;
            brw_q    <= brw_d;
            cnt_q    <= cnt_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            zero_q   <= zero_d;
        end
    end

    // Next-state logic and cell pin drive; pins are quiet outside RUN.
    always_comb begin
        state_d   = state_q;
        a_sh_d    = a_sh_q;
        b_sh_d    = b_sh_q;
        res_d     = res_q;
        brw_d     = brw_q;
        cnt_d     = cnt_q;
        diff_d    = diff_q;
        borrow_d  = borrow_q;
        zero_d    = zero_q;
        fs_a      = 1'b0;
        fs_b      = 1'b0;
        fs_bin    = 1'b0;
        res_nxt_s = {fs_diff, res_q[WIDTH-1:1]};
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d  = S_RUN;
                    a_sh_d   = a;
                    b_sh_d   = b;
                    res_d    = '0;
                    brw_d    = 1'b0;
                    cnt_d    = '0;
                    diff_d   = '0;
                    borrow_d = 1'b0;
                    zero_d   = 1'b0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_RUN: begin
                fs_a   = a_sh_q[0];
                fs_b   = b_sh_q[0];
                fs_bin = brw_q;
                res_d  = res_nxt_s;
                brw_d  = fs_bout;
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                if (cnt_q == LAST_BIT) begin
                    // Last bit: the freshly shifted result is the final difference.
                    state_d  = S_DONE;
                    diff_d   = res_nxt_s;
                    borrow_d = fs_bout;
                    zero_d   = (res_nxt_s == '0);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign done       = (state_q == S_DONE);
    assign diff       = diff_q;
    assign borrow_out = borrow_q;
    assign zero       = zero_q;

endmodule
